// File: rtl/arm_multicycle_ctrl.sv
// rtl/arm_multicycle_ctrl.sv - multicycle ARMv4-subset control FSM with NZCV flags and retired-instruction counter
module arm_multicycle_ctrl #(
    parameter int ALU_CTRL_W = 2,
    parameter int EN_WAIT    = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_instr,
    input  logic [3:0]            i_alu_flags,
    input  logic                  i_mem_ready,
    output logic                  o_pc_write,
    output logic                  o_adr_src,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_ir_write,
    output logic                  o_reg_write,
    output logic                  o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic [1:0]            o_result_src,
    output logic [1:0]            o_imm_src,
    output logic [1:0]            o_reg_src,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic [3:0]            o_flags,
    output logic [CNT_W-1:0]      o_instret,
    output logic [3:0]            o_state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_instret;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_ready;
    logic       w_cond_ex;
    logic       w_is_cmp;
    logic       w_is_logic;
    logic [2:0] w_alu_dec;
    logic       w_flag_upd;
    logic       w_unused_instr;

    assign w_cond         = i_instr[31:28];
    assign w_op           = i_instr[27:26];
    assign w_funct        = i_instr[25:20];
    assign w_rd           = i_instr[15:12];
    assign w_unused_instr = ^{i_instr[19:16], i_instr[11:0]};
    assign w_ready        = (EN_WAIT != 0) ? i_mem_ready : 1'b1;
    assign w_is_cmp       = (w_funct[4:1] == 4'b1010);

    // Flags are {N,Z,C,V}
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Logical ops only own N and Z; unknown encodings fall back to ADD
    always_comb begin
        w_alu_dec  = 3'd0;
        w_is_logic = 1'b0;
        case (w_funct[4:1])
            4'b0100: w_alu_dec = 3'd0;
            4'b0010,
            4'b1010: w_alu_dec = 3'd1;
            4'b0000: begin w_alu_dec = 3'd2; w_is_logic = 1'b1; end
            4'b1100: begin w_alu_dec = 3'd3; w_is_logic = 1'b1; end
            4'b0001: begin
                if (ALU_CTRL_W >= 3) begin
                    w_alu_dec  = 3'd4;
                    w_is_logic = 1'b1;
                end
            end
            default: w_alu_dec = 3'd0;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        o_pc_write    = 1'b0;
        o_adr_src     = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_result_src  = 2'b00;
        o_alu_control = '0;
        o_imm_src     = w_op;
        o_reg_src     = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
        case (r_state)
            S_FETCH: begin
                o_mem_read   = 1'b1;
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = w_ready;
                o_pc_write   = w_ready;
                w_next       = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                case (w_op)
                    2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                o_alu_src_b = 2'b01;
                if (!w_cond_ex)      w_next = S_FETCH;
                else if (w_funct[0]) w_next = S_MEMRD;
                else                 w_next = S_MEMWR;
            end
            S_MEMRD: begin
                o_adr_src  = 1'b1;
                o_mem_read = 1'b1;
                w_next     = w_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                o_result_src = 2'b01;
                o_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                o_adr_src   = 1'b1;
                o_mem_write = 1'b1;
                w_next      = w_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                o_alu_control = w_alu_dec[ALU_CTRL_W-1:0];
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                o_alu_src_b   = 2'b01;
                o_alu_control = w_alu_dec[ALU_CTRL_W-1:0];
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_write = w_cond_ex & ~w_is_cmp;
                o_pc_write  = w_cond_ex & ~w_is_cmp & (w_rd == 4'd15);
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_pc_write   = w_cond_ex;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // Reset overrides everything so no write or request leaks out mid-abort
        if (!i_rst_n) begin
            o_pc_write    = 1'b0;
            o_adr_src     = 1'b0;
            o_mem_read    = 1'b0;
            o_mem_write   = 1'b0;
            o_ir_write    = 1'b0;
            o_reg_write   = 1'b0;
            o_alu_src_a   = 1'b0;
            o_alu_src_b   = 2'b00;
            o_result_src  = 2'b00;
            o_alu_control = '0;
            o_imm_src     = 2'b00;
            o_reg_src     = 2'b00;
        end
    end

    assign w_flag_upd = (r_state == S_ALUWB) & w_cond_ex & (w_funct[0] | w_is_cmp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_flag_upd)
                r_flags <= w_is_logic ? {i_alu_flags[3:2], r_flags[1:0]} : i_alu_flags;
            if ((r_state != S_FETCH) && (w_next == S_FETCH))
                r_instret <= r_instret + 1'b1;
        end
    end

    assign o_flags     = r_flags;
    assign o_instret   = r_instret;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb/tb_arm_multicycle_ctrl.sv - scoreboard bench for arm_multicycle_ctrl using directed instruction sequences
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  alu_flags = 4'h0;
    logic        mem_ready = 1'b1;
    logic        pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, result_src, imm_src, reg_src, alu_control;
    logic [3:0]  flags, state_dbg;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_write,adr_src,mem_read,mem_write,ir_write,reg_write,alu_src_a,alu_src_b,result_src,alu_control}
    localparam logic [12:0] C_FE    = 13'b1_0_1_0_1_0_1_10_10_00;
    localparam logic [12:0] C_FW    = 13'b0_0_1_0_0_0_1_10_10_00;
    localparam logic [12:0] C_DE    = 13'b0_0_0_0_0_0_1_10_00_00;
    localparam logic [12:0] C_MA    = 13'b0_0_0_0_0_0_0_01_00_00;
    localparam logic [12:0] C_MR    = 13'b0_1_1_0_0_0_0_00_00_00;
    localparam logic [12:0] C_MB    = 13'b0_0_0_0_0_1_0_00_01_00;
    localparam logic [12:0] C_MW    = 13'b0_1_0_1_0_0_0_00_00_00;
    localparam logic [12:0] C_XADD  = 13'b0_0_0_0_0_0_0_00_00_00;
    localparam logic [12:0] C_XSUB  = 13'b0_0_0_0_0_0_0_00_00_01;
    localparam logic [12:0] C_XAND  = 13'b0_0_0_0_0_0_0_00_00_10;
    localparam logic [12:0] C_XIADD = 13'b0_0_0_0_0_0_0_01_00_00;
    localparam logic [12:0] C_WBRW  = 13'b0_0_0_0_0_1_0_00_00_00;
    localparam logic [12:0] C_WBNO  = 13'b0_0_0_0_0_0_0_00_00_00;
    localparam logic [12:0] C_WBPC  = 13'b1_0_0_0_0_1_0_00_00_00;
    localparam logic [12:0] C_BRT   = 13'b1_0_0_0_0_0_0_01_10_00;
    localparam logic [12:0] C_BRF   = 13'b0_0_0_0_0_0_0_01_10_00;
    localparam logic [12:0] C_ZERO  = 13'b0;

    localparam logic [31:0] I_ADD  = 32'hE0821003;
    localparam logic [31:0] I_LDR  = 32'hE5921000;
    localparam logic [31:0] I_CMP  = 32'hE1510001;
    localparam logic [31:0] I_BEQ  = 32'h0A000002;
    localparam logic [31:0] I_BNE  = 32'h1A000002;
    localparam logic [31:0] I_STNE = 32'h15821000;
    localparam logic [31:0] I_ANDS = 32'hE0111002;
    localparam logic [31:0] I_ADDI = 32'hE282F001;
    localparam logic [31:0] I_NOP  = 32'hEC000000;
    localparam logic [31:0] I_STR  = 32'hE5821000;

    typedef struct {
        logic [3:0]  st;
        logic [12:0] ctl;
        logic [3:0]  ri;
        logic [3:0]  fl;
        logic [31:0] n;
    } exp_t;
    exp_t q[$];

    arm_multicycle_ctrl #(.ALU_CTRL_W(2), .EN_WAIT(1), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_alu_flags(alu_flags),
        .i_mem_ready(mem_ready), .o_pc_write(pc_write), .o_adr_src(adr_src),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_ir_write(ir_write),
        .o_reg_write(reg_write), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_result_src(result_src), .o_imm_src(imm_src), .o_reg_src(reg_src),
        .o_alu_control(alu_control), .o_flags(flags), .o_instret(instret),
        .o_state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", {28'h0, state_dbg}, {28'h0, e.st});
            chk("ctrl", {19'h0, pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                         alu_src_a, alu_src_b, result_src, alu_control}, {19'h0, e.ctl});
            chk("regsrc_immsrc", {28'h0, reg_src, imm_src}, {28'h0, e.ri});
            chk("flags", {28'h0, flags}, {28'h0, e.fl});
            chk("instret", instret, e.n);
        end
    end

    task automatic cyc(input logic r, input logic [31:0] ins, input logic [3:0] af,
                       input logic rdy, input logic [3:0] st, input logic [12:0] ctl,
                       input logic [3:0] ri, input logic [3:0] fl, input logic [31:0] n);
        exp_t e;
        rst_n     = r;
        instr     = ins;
        alu_flags = af;
        mem_ready = rdy;
        e.st = st; e.ctl = ctl; e.ri = ri; e.fl = fl; e.n = n;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(0, I_ADD, 4'h0, 1, 0, C_ZERO, 4'b0000, 4'h0, 0);
        cyc(0, I_ADD, 4'h0, 1, 0, C_ZERO, 4'b0000, 4'h0, 0);
        // ADD r1,r2,r3
        cyc(1, I_ADD, 4'h0, 1, 0, C_FE,   4'b0000, 4'h0, 0);
        cyc(1, I_ADD, 4'h0, 1, 1, C_DE,   4'b0000, 4'h0, 0);
        cyc(1, I_ADD, 4'h0, 1, 6, C_XADD, 4'b0000, 4'h0, 0);
        cyc(1, I_ADD, 4'hF, 1, 8, C_WBRW, 4'b0000, 4'h0, 0);
        // LDR with a fetch stall and three MEMRD wait states
        cyc(1, I_LDR, 4'h0, 0, 0, C_FW,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 1, 0, C_FE,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 1, 1, C_DE,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 1, 2, C_MA,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 0, 3, C_MR,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 0, 3, C_MR,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 0, 3, C_MR,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 1, 3, C_MR,   4'b0001, 4'h0, 1);
        cyc(1, I_LDR, 4'h0, 1, 4, C_MB,   4'b0001, 4'h0, 1);
        // CMP r1,r1 -> flags 0110
        cyc(1, I_CMP, 4'h0, 1, 0, C_FE,   4'b0000, 4'h0, 2);
        cyc(1, I_CMP, 4'h0, 1, 1, C_DE,   4'b0000, 4'h0, 2);
        cyc(1, I_CMP, 4'h0, 1, 6, C_XSUB, 4'b0000, 4'h0, 2);
        cyc(1, I_CMP, 4'h6, 1, 8, C_WBNO, 4'b0000, 4'h0, 2);
        // BEQ taken, BNE not taken
        cyc(1, I_BEQ, 4'h0, 1, 0, C_FE,   4'b0110, 4'h6, 3);
        cyc(1, I_BEQ, 4'h0, 1, 1, C_DE,   4'b0110, 4'h6, 3);
        cyc(1, I_BEQ, 4'h0, 1, 9, C_BRT,  4'b0110, 4'h6, 3);
        cyc(1, I_BNE, 4'h0, 1, 0, C_FE,   4'b0110, 4'h6, 4);
        cyc(1, I_BNE, 4'h0, 1, 1, C_DE,   4'b0110, 4'h6, 4);
        cyc(1, I_BNE, 4'h0, 1, 9, C_BRF,  4'b0110, 4'h6, 4);
        // STRNE with Z=1: skips memory access
        cyc(1, I_STNE, 4'h0, 1, 0, C_FE,  4'b1001, 4'h6, 5);
        cyc(1, I_STNE, 4'h0, 1, 1, C_DE,  4'b1001, 4'h6, 5);
        cyc(1, I_STNE, 4'h0, 1, 2, C_MA,  4'b1001, 4'h6, 5);
        // CMP to set flags 0011, then ANDS keeps C,V
        cyc(1, I_CMP, 4'h0, 1, 0, C_FE,   4'b0000, 4'h6, 6);
        cyc(1, I_CMP, 4'h0, 1, 1, C_DE,   4'b0000, 4'h6, 6);
        cyc(1, I_CMP, 4'h0, 1, 6, C_XSUB, 4'b0000, 4'h6, 6);
        cyc(1, I_CMP, 4'h3, 1, 8, C_WBNO, 4'b0000, 4'h6, 6);
        cyc(1, I_ANDS, 4'h0, 1, 0, C_FE,  4'b0000, 4'h3, 7);
        cyc(1, I_ANDS, 4'h0, 1, 1, C_DE,  4'b0000, 4'h3, 7);
        cyc(1, I_ANDS, 4'h0, 1, 6, C_XAND, 4'b0000, 4'h3, 7);
        cyc(1, I_ANDS, 4'hC, 1, 8, C_WBRW, 4'b0000, 4'h3, 7);
        // ADD immediate into r15
        cyc(1, I_ADDI, 4'h0, 1, 0, C_FE,   4'b0000, 4'hF, 8);
        cyc(1, I_ADDI, 4'h0, 1, 1, C_DE,   4'b0000, 4'hF, 8);
        cyc(1, I_ADDI, 4'h0, 1, 7, C_XIADD, 4'b0000, 4'hF, 8);
        cyc(1, I_ADDI, 4'h0, 1, 8, C_WBPC, 4'b0000, 4'hF, 8);
        // op=11 retires as NOP from DECODE
        cyc(1, I_NOP, 4'h0, 1, 0, C_FE,   4'b0011, 4'hF, 9);
        cyc(1, I_NOP, 4'h0, 1, 1, C_DE,   4'b0011, 4'hF, 9);
        // STR stalled in MEMWR, then reset aborts it
        cyc(1, I_STR, 4'h0, 1, 0, C_FE,   4'b1001, 4'hF, 10);
        cyc(1, I_STR, 4'h0, 1, 1, C_DE,   4'b1001, 4'hF, 10);
        cyc(1, I_STR, 4'h0, 1, 2, C_MA,   4'b1001, 4'hF, 10);
        cyc(1, I_STR, 4'h0, 0, 5, C_MW,   4'b1001, 4'hF, 10);
        cyc(1, I_STR, 4'h0, 0, 5, C_MW,   4'b1001, 4'hF, 10);
        cyc(0, I_STR, 4'h0, 0, 0, C_ZERO, 4'b0000, 4'h0, 0);
        cyc(1, I_ADD, 4'h0, 1, 0, C_FE,   4'b0000, 4'h0, 0);
        cyc(1, I_ADD, 4'h0, 1, 1, C_DE,   4'b0000, 4'h0, 0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
